// File: rtl/risc_sequencer.sv
// risc_sequencer: multi-cycle fetch/decode/execute controller for the simple
// RISC CPU. All strobes are Moore outputs of the state. The only exception is
// the branch-taken decision, which also looks at Z/N/V.
// Build option: define RISC_SEQ_BRANCH_EN to add conditional branches
// (opcode 001). Without it, opcode 001 halts and pc_sel stays 0.
module risc_sequencer #(
  parameter int ST_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  output logic       waiting,
  output logic       halted,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       clear_pc,
  output logic       load_pc,
  output logic       pc_sel,
  output logic       load_ir,
  output logic       load_addr,
  output logic       sel_addr,
  output logic       ram_w_en
);

  typedef enum logic [ST_W-1:0] {
    S_RST, S_WAIT, S_IF1, S_IF2, S_UPC, S_DEC, S_WBI, S_GA, S_GB, S_GBD,
    S_EX, S_EXZ, S_EXZ2, S_CMP, S_WB, S_ADR, S_LDA, S_MR1, S_MR2, S_MW,
    S_HLT, S_BR
  } state_t;

  state_t state, state_nx;

`ifdef RISC_SEQ_BRANCH_EN
  logic br_taken;

  // Branch condition decode from the status flags.
  always_comb begin
    br_taken = 1'b0;
    case (cond)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = Z;
      3'b010:  br_taken = ~Z;
      3'b011:  br_taken = N ^ V;
      3'b100:  br_taken = (N ^ V) | Z;
      default: br_taken = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags = ^{Z, N, V, cond};
`endif

  // State register. Reset is synchronous and active high.
  always_ff @(posedge clk) begin
    if (rst_n) state <= S_RST;
    else       state <= state_nx;
  end

  // Next-state logic and Moore strobes.
  // Shared states (GA, GB, LDA) choose their successor from the decoder fields.
  // Those fields come from the IR and stay stable for the whole instruction.
  always_comb begin
    state_nx  = state;
    waiting   = 1'b0;
    halted    = 1'b0;
    reg_sel   = 2'b00;
    wb_sel    = 2'b00;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    clear_pc  = 1'b0;
    load_pc   = 1'b0;
    pc_sel    = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    sel_addr  = 1'b0;
    ram_w_en  = 1'b0;
    case (state)
      S_RST: begin
        clear_pc = 1'b1;
        load_pc  = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        waiting = 1'b1;
        if (start) state_nx = S_IF1;
      end
      S_IF1: begin
        sel_addr = 1'b1;
        state_nx = S_IF2;
      end
      S_IF2: begin
        sel_addr = 1'b1;
        load_ir  = 1'b1;
        state_nx = S_UPC;
      end
      S_UPC: begin
        load_pc  = 1'b1;
        state_nx = S_DEC;
      end
      S_DEC: begin
        case (opcode)
          3'b110: begin
            if (ALU_op == 2'b10)      state_nx = S_WBI;
            else if (ALU_op == 2'b00) state_nx = S_GB;
            else                      state_nx = S_HLT;
          end
          3'b101:  state_nx = (ALU_op == 2'b11) ? S_GB : S_GA;
          3'b011:  state_nx = S_GA;
          3'b100:  state_nx = S_GA;
`ifdef RISC_SEQ_BRANCH_EN
          3'b001:  state_nx = S_BR;
`endif
          default: state_nx = S_HLT;
        endcase
      end
      S_WBI: begin
        reg_sel  = 2'b10;
        wb_sel   = 2'b10;
        w_en     = 1'b1;
        state_nx = S_IF1;
      end
      S_GA: begin
        reg_sel  = 2'b10;
        en_A     = 1'b1;
        state_nx = (opcode == 3'b101) ? S_GB : S_ADR;
      end
      S_GB: begin
        reg_sel = 2'b00;
        en_B    = 1'b1;
        if (opcode == 3'b101 && ALU_op == 2'b01)      state_nx = S_CMP;
        else if (opcode == 3'b101 && ALU_op != 2'b11) state_nx = S_EX;
        else                                          state_nx = S_EXZ;
      end
      S_GBD: begin
        reg_sel  = 2'b01;
        en_B     = 1'b1;
        state_nx = S_EXZ2;
      end
      S_EX: begin
        en_C     = 1'b1;
        state_nx = S_WB;
      end
      S_EXZ: begin
        sel_A    = 1'b1;
        en_C     = 1'b1;
        state_nx = S_WB;
      end
      S_EXZ2: begin
        sel_A    = 1'b1;
        en_C     = 1'b1;
        state_nx = S_MW;
      end
      S_CMP: begin
        en_status = 1'b1;
        state_nx  = S_IF1;
      end
      S_WB: begin
        reg_sel  = 2'b01;
        wb_sel   = 2'b00;
        w_en     = 1'b1;
        state_nx = S_IF1;
      end
      S_ADR: begin
        sel_B    = 1'b1;
        en_C     = 1'b1;
        state_nx = S_LDA;
      end
      S_LDA: begin
        load_addr = 1'b1;
        state_nx  = (opcode == 3'b011) ? S_MR1 : S_GBD;
      end
      S_MR1: begin
        state_nx = S_MR2;
      end
      S_MR2: begin
        reg_sel  = 2'b01;
        wb_sel   = 2'b11;
        w_en     = 1'b1;
        state_nx = S_IF1;
      end
      S_MW: begin
        ram_w_en = 1'b1;
        state_nx = S_IF1;
      end
      S_HLT: begin
        halted = 1'b1;
        if (start) state_nx = S_RST;
      end
`ifdef RISC_SEQ_BRANCH_EN
      S_BR: begin
        load_pc  = br_taken;
        pc_sel   = br_taken;
        state_nx = S_IF1;
      end
`endif
      default: state_nx = S_RST;
    endcase
  end

endmodule

// File: tb/tb_risc_sequencer.sv
// tb_risc_sequencer: directed, table-driven check of the risc_sequencer strobes,
// followed by IF1-to-IF1 latency measurements for each instruction class.
module tb_risc_sequencer;

  logic       clk, rst_n, start;
  logic [2:0] opcode, cond;
  logic [1:0] ALU_op;
  logic       Z, N, V;
  logic       waiting, halted, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
  logic       clear_pc, load_pc, pc_sel, load_ir, load_addr, sel_addr, ram_w_en;
  logic [1:0] reg_sel, wb_sel;
  logic [19:0] obs;

  risc_sequencer #(.ST_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .ALU_op(ALU_op),
    .cond(cond), .Z(Z), .N(N), .V(V), .waiting(waiting), .halted(halted),
    .reg_sel(reg_sel), .wb_sel(wb_sel), .w_en(w_en), .en_A(en_A), .en_B(en_B),
    .en_C(en_C), .en_status(en_status), .sel_A(sel_A), .sel_B(sel_B),
    .clear_pc(clear_pc), .load_pc(load_pc), .pc_sel(pc_sel), .load_ir(load_ir),
    .load_addr(load_addr), .sel_addr(sel_addr), .ram_w_en(ram_w_en)
  );

  assign obs = {waiting, halted, reg_sel, wb_sel, w_en, en_A, en_B, en_C,
                en_status, sel_A, sel_B, clear_pc, load_pc, pc_sel, load_ir,
                load_addr, sel_addr, ram_w_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bit masks, in the same order as obs
  localparam logic [19:0] B_WAIT = 20'd1 << 19;
  localparam logic [19:0] B_HALT = 20'd1 << 18;
  localparam logic [19:0] RS_RD  = 20'd1 << 16;
  localparam logic [19:0] RS_RN  = 20'd2 << 16;
  localparam logic [19:0] WB_IMM = 20'd2 << 14;
  localparam logic [19:0] WB_MD  = 20'd3 << 14;
  localparam logic [19:0] B_WEN  = 20'd1 << 13;
  localparam logic [19:0] B_ENA  = 20'd1 << 12;
  localparam logic [19:0] B_ENB  = 20'd1 << 11;
  localparam logic [19:0] B_ENC  = 20'd1 << 10;
  localparam logic [19:0] B_ENS  = 20'd1 << 9;
  localparam logic [19:0] B_SELA = 20'd1 << 8;
  localparam logic [19:0] B_SELB = 20'd1 << 7;
  localparam logic [19:0] B_CLR  = 20'd1 << 6;
  localparam logic [19:0] B_LDPC = 20'd1 << 5;
  localparam logic [19:0] B_PCS  = 20'd1 << 4;
  localparam logic [19:0] B_LDIR = 20'd1 << 3;
  localparam logic [19:0] B_LDAD = 20'd1 << 2;
  localparam logic [19:0] B_SADR = 20'd1 << 1;
  localparam logic [19:0] B_RAMW = 20'd1;

  // Expected strobes for each state
  localparam logic [19:0] E_RST  = B_CLR | B_LDPC;
  localparam logic [19:0] E_WAIT = B_WAIT;
  localparam logic [19:0] E_IF1  = B_SADR;
  localparam logic [19:0] E_IF2  = B_SADR | B_LDIR;
  localparam logic [19:0] E_UPC  = B_LDPC;
  localparam logic [19:0] E_DEC  = 20'd0;
  localparam logic [19:0] E_WBI  = RS_RN | WB_IMM | B_WEN;
  localparam logic [19:0] E_GA   = RS_RN | B_ENA;
  localparam logic [19:0] E_GB   = B_ENB;
  localparam logic [19:0] E_GBD  = RS_RD | B_ENB;
  localparam logic [19:0] E_EX   = B_ENC;
  localparam logic [19:0] E_EXZ  = B_SELA | B_ENC;
  localparam logic [19:0] E_CMP  = B_ENS;
  localparam logic [19:0] E_WB   = RS_RD | B_WEN;
  localparam logic [19:0] E_ADR  = B_SELB | B_ENC;
  localparam logic [19:0] E_LDA  = B_LDAD;
  localparam logic [19:0] E_MR1  = 20'd0;
  localparam logic [19:0] E_MR2  = RS_RD | WB_MD | B_WEN;
  localparam logic [19:0] E_MW   = B_RAMW;
  localparam logic [19:0] E_HLT  = B_HALT;
  localparam logic [19:0] E_BRT  = B_LDPC | B_PCS;
  localparam logic [19:0] E_BRN  = 20'd0;

  typedef struct {
    logic        rst;
    logic        st;
    logic [2:0]  opc;
    logic [1:0]  op;
    logic [2:0]  cnd;
    logic [2:0]  znv;
    logic [19:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0] opc;
    logic [1:0] op;
    logic [2:0] cnd;
    logic [2:0] znv;
    int         lat;
  } lat_t;

  vec_t vecs[$];
  lat_t lats[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic s, input logic [2:0] o,
                     input logic [1:0] p, input logic [2:0] c,
                     input logic [2:0] f, input logic [19:0] e);
    vec_t v;
    v.rst = r; v.st = s; v.opc = o; v.op = p; v.cnd = c; v.znv = f; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic fetch(input logic [2:0] o, input logic [1:0] p,
                       input logic [2:0] c, input logic [2:0] f);
    add(0, 0, o, p, c, f, E_IF1);
    add(0, 0, o, p, c, f, E_IF2);
    add(0, 0, o, p, c, f, E_UPC);
    add(0, 0, o, p, c, f, E_DEC);
  endtask

  task automatic ex(input logic [2:0] o, input logic [1:0] p, input logic [19:0] e);
    add(0, 0, o, p, 3'b000, 3'b000, e);
  endtask

  task automatic drive(input logic r, input logic s, input logic [2:0] o,
                       input logic [1:0] p, input logic [2:0] c, input logic [2:0] f);
    rst_n = r; start = s; opcode = o; ALU_op = p; cond = c;
    {Z, N, V} = f;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    drive(1, 0, 3'b000, 2'b00, 3'b000, 3'b000);
    @(negedge clk);

    // Reset held, then start held high through RST and WAIT
    add(1, 0, 3'b000, 2'b00, 3'b000, 3'b000, E_RST);
    add(0, 1, 3'b000, 2'b00, 3'b000, 3'b000, E_RST);
    add(0, 1, 3'b000, 2'b00, 3'b000, 3'b000, E_WAIT);
    // MOV imm
    fetch(3'b110, 2'b10, 3'b000, 3'b000); ex(3'b110, 2'b10, E_WBI);
    // ADD
    fetch(3'b101, 2'b00, 3'b000, 3'b000);
    ex(3'b101, 2'b00, E_GA); ex(3'b101, 2'b00, E_GB);
    ex(3'b101, 2'b00, E_EX); ex(3'b101, 2'b00, E_WB);
    // STR
    fetch(3'b100, 2'b00, 3'b000, 3'b000);
    ex(3'b100, 2'b00, E_GA); ex(3'b100, 2'b00, E_ADR); ex(3'b100, 2'b00, E_LDA);
    ex(3'b100, 2'b00, E_GBD); ex(3'b100, 2'b00, E_EXZ); ex(3'b100, 2'b00, E_MW);
    // LDR
    fetch(3'b011, 2'b00, 3'b000, 3'b000);
    ex(3'b011, 2'b00, E_GA); ex(3'b011, 2'b00, E_ADR); ex(3'b011, 2'b00, E_LDA);
    ex(3'b011, 2'b00, E_MR1); ex(3'b011, 2'b00, E_MR2);
    // MOV reg
    fetch(3'b110, 2'b00, 3'b000, 3'b000);
    ex(3'b110, 2'b00, E_GB); ex(3'b110, 2'b00, E_EXZ); ex(3'b110, 2'b00, E_WB);
    // MVN
    fetch(3'b101, 2'b11, 3'b000, 3'b000);
    ex(3'b101, 2'b11, E_GB); ex(3'b101, 2'b11, E_EXZ); ex(3'b101, 2'b11, E_WB);
    // AND
    fetch(3'b101, 2'b10, 3'b000, 3'b000);
    ex(3'b101, 2'b10, E_GA); ex(3'b101, 2'b10, E_GB);
    ex(3'b101, 2'b10, E_EX); ex(3'b101, 2'b10, E_WB);
    // CMP
    fetch(3'b101, 2'b01, 3'b000, 3'b000);
    ex(3'b101, 2'b01, E_GA); ex(3'b101, 2'b01, E_GB); ex(3'b101, 2'b01, E_CMP);
    // STR aborted by reset in GBD: no MW follows, and WAIT holds while start=0
    fetch(3'b100, 2'b00, 3'b000, 3'b000);
    ex(3'b100, 2'b00, E_GA); ex(3'b100, 2'b00, E_ADR); ex(3'b100, 2'b00, E_LDA);
    add(1, 0, 3'b100, 2'b00, 3'b000, 3'b000, E_GBD);
    add(0, 0, 3'b100, 2'b00, 3'b000, 3'b000, E_RST);
    add(0, 0, 3'b100, 2'b00, 3'b000, 3'b000, E_WAIT);
    add(0, 0, 3'b100, 2'b00, 3'b000, 3'b000, E_WAIT);
    add(0, 1, 3'b100, 2'b00, 3'b000, 3'b000, E_WAIT);
    // STR with reset in the MW cycle: the write strobe still shows in that cycle
    fetch(3'b100, 2'b00, 3'b000, 3'b000);
    ex(3'b100, 2'b00, E_GA); ex(3'b100, 2'b00, E_ADR); ex(3'b100, 2'b00, E_LDA);
    ex(3'b100, 2'b00, E_GBD); ex(3'b100, 2'b00, E_EXZ);
    add(1, 0, 3'b100, 2'b00, 3'b000, 3'b000, E_MW);
    add(0, 1, 3'b100, 2'b00, 3'b000, 3'b000, E_RST);
    add(0, 1, 3'b100, 2'b00, 3'b000, 3'b000, E_WAIT);
    // Unused MOV encoding halts; start restarts through RST
    fetch(3'b110, 2'b01, 3'b000, 3'b000);
    ex(3'b110, 2'b01, E_HLT); ex(3'b110, 2'b01, E_HLT);
    add(0, 1, 3'b110, 2'b01, 3'b000, 3'b000, E_HLT);
    add(0, 1, 3'b110, 2'b01, 3'b000, 3'b000, E_RST);
    add(0, 1, 3'b110, 2'b01, 3'b000, 3'b000, E_WAIT);
    // Opcode 000 halts; reset leaves HLT
    fetch(3'b000, 2'b00, 3'b000, 3'b000);
    add(1, 0, 3'b000, 2'b00, 3'b000, 3'b000, E_HLT);
    add(0, 1, 3'b000, 2'b00, 3'b000, 3'b000, E_RST);
    add(0, 1, 3'b000, 2'b00, 3'b000, 3'b000, E_WAIT);
`ifdef RISC_SEQ_BRANCH_EN
    // Branches: BEQ Z=1 taken, BNE Z=1 not, BLT N!=V taken, BLE with no
    // condition true is not taken, BLE Z=1 taken, always, never
    fetch(3'b001, 2'b00, 3'b001, 3'b100); add(0, 0, 3'b001, 2'b00, 3'b001, 3'b100, E_BRT);
    fetch(3'b001, 2'b00, 3'b010, 3'b100); add(0, 0, 3'b001, 2'b00, 3'b010, 3'b100, E_BRN);
    fetch(3'b001, 2'b00, 3'b011, 3'b010); add(0, 0, 3'b001, 2'b00, 3'b011, 3'b010, E_BRT);
    fetch(3'b001, 2'b00, 3'b100, 3'b011); add(0, 0, 3'b001, 2'b00, 3'b100, 3'b011, E_BRN);
    fetch(3'b001, 2'b00, 3'b100, 3'b100); add(0, 0, 3'b001, 2'b00, 3'b100, 3'b100, E_BRT);
    fetch(3'b001, 2'b00, 3'b000, 3'b000); add(0, 0, 3'b001, 2'b00, 3'b000, 3'b000, E_BRT);
    fetch(3'b001, 2'b00, 3'b111, 3'b100); add(0, 0, 3'b001, 2'b00, 3'b111, 3'b100, E_BRN);
`else
    fetch(3'b001, 2'b00, 3'b000, 3'b100);
    ex(3'b001, 2'b00, E_HLT);
    add(0, 1, 3'b001, 2'b00, 3'b000, 3'b000, E_HLT);
    add(0, 1, 3'b001, 2'b00, 3'b000, 3'b000, E_RST);
    add(0, 1, 3'b001, 2'b00, 3'b000, 3'b000, E_WAIT);
`endif
    // HALT held for 20 cycles, then start restarts through RST and WAIT
    fetch(3'b111, 2'b00, 3'b000, 3'b000);
    for (int i = 0; i < 20; i++) ex(3'b111, 2'b00, E_HLT);
    add(0, 1, 3'b111, 2'b00, 3'b000, 3'b000, E_HLT);
    add(0, 1, 3'b111, 2'b00, 3'b000, 3'b000, E_RST);
    add(0, 1, 3'b111, 2'b00, 3'b000, 3'b000, E_WAIT);
    add(0, 0, 3'b110, 2'b10, 3'b000, 3'b000, E_IF1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].opc, vecs[i].op, vecs[i].cnd, vecs[i].znv);
      #1;
      n_cmp++;
      if (obs !== vecs[i].exp) begin
        n_bad++;
        $display("FAIL step %0d: outputs %05h, required %05h", i, obs, vecs[i].exp);
      end
      @(negedge clk);
    end

    // IF1-to-IF1 latency per instruction class
    lats.push_back('{3'b110, 2'b10, 3'b000, 3'b000, 5});
    lats.push_back('{3'b110, 2'b00, 3'b000, 3'b000, 7});
    lats.push_back('{3'b101, 2'b11, 3'b000, 3'b000, 7});
    lats.push_back('{3'b101, 2'b01, 3'b000, 3'b000, 7});
    lats.push_back('{3'b101, 2'b00, 3'b000, 3'b000, 8});
    lats.push_back('{3'b101, 2'b10, 3'b000, 3'b000, 8});
    lats.push_back('{3'b011, 2'b00, 3'b000, 3'b000, 9});
    lats.push_back('{3'b100, 2'b00, 3'b000, 3'b000, 10});
`ifdef RISC_SEQ_BRANCH_EN
    lats.push_back('{3'b001, 2'b00, 3'b001, 3'b100, 5});
    lats.push_back('{3'b001, 2'b00, 3'b010, 3'b100, 5});
`endif

    // The last table step left the sequencer in IF2 of a MOV imm
    drive(0, 0, 3'b110, 2'b10, 3'b000, 3'b000);
    #1;
    k = 0;
    while (obs !== E_IF1 && k < 20) begin
      @(negedge clk); #1; k++;
    end
    n_cmp++;
    if (obs !== E_IF1) begin
      n_bad++;
      $display("FAIL find_if1: outputs %05h after %0d cycles, required %05h", obs, k, E_IF1);
    end
    foreach (lats[i]) begin
      drive(0, 0, lats[i].opc, lats[i].op, lats[i].cnd, lats[i].znv);
      n = 0;
      do begin
        @(negedge clk); #1; n++;
      end while (obs !== E_IF1 && n < 40);
      n_cmp++;
      if (n != lats[i].lat) begin
        n_bad++;
        $display("FAIL latency %0d (opcode %b op %b): %0d cycles, required %0d",
                 i, lats[i].opc, lats[i].op, n, lats[i].lat);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
